fim_gram_sdp_reader: RTL
========================

# fim_gram_sdp_reader

Read-side controller for the team's simple dual-port RAM in mode 3 (2-cycle read latency) or mode 1/2 (1-cycle). Accepts a burst command (start address, word count) and drives the RAM read address. It tracks words in flight through the RAM read pipeline and returns the data on a valid/ready stream with a last-word marker. An internal output buffer sized to the read latency absorbs downstream backpressure without losing or duplicating words.

## Interface
- BUS_SIZE_ADDR, 4, RAM address width; RAM depth = 2**BUS_SIZE_ADDR.
- BUS_SIZE_DATA, 32, RAM data width.
- RD_LATENCY, 2, RAM read latency in cycles; legal values 1 or 2.
- LEN_WIDTH, BUS_SIZE_ADDR+1, width of the burst word count.
- OUT_DEPTH (localparam), RD_LATENCY+2, output buffer entries.

- clk  in  1  single clock for all logic.
- reset  in  1  synchronous reset, active-high.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE and not in reset.
- cmd_addr  in  BUS_SIZE_ADDR  first RAM address of the burst.
- cmd_len  in  LEN_WIDTH  number of words, 0..2**BUS_SIZE_ADDR.
- ram_raddr  out  BUS_SIZE_ADDR  read address to the RAM; registered.
- ram_dout  in  BUS_SIZE_DATA  RAM read data, RD_LATENCY cycles after the address.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  BUS_SIZE_DATA  output word; don't-care when out_valid=0.
- out_last  out  1  final word of the burst; qualified by out_valid.
- busy  out  1  high from command accept until the final word is consumed.

## Operation
- The command handshake completes on cmd_valid & cmd_ready at a clock edge. The block latches the address into addr_q and the length into rem_q.
- States:
  - IDLE: cmd_ready=1. On accept with cmd_len≠0, go to ISSUE. With cmd_len=0, stay in IDLE; no output and busy stays 0.
  - ISSUE: a read is issued in a cycle when rem_q≠0 and inflight+buf_count < OUT_DEPTH.
    - A read drives ram_raddr=addr_q for that cycle, then increments addr_q modulo 2**BUS_SIZE_ADDR (15→0 wraps) and decrements rem_q.
    - Issuing the final word moves the block to DRAIN.
  - DRAIN: wait until inflight=0 and the buffer is empty, then go to IDLE.
- Valid pipeline: a shift register of depth RD_LATENCY carries {valid, last} beside the RAM. When an entry emerges valid, ram_dout and last are written into the output buffer.
- The credit check guarantees the buffer never overflows. A write to a full buffer is an assertion failure.
- Output buffer: FIFO of OUT_DEPTH entries. out_valid = not empty. Pop on out_valid & out_ready.
- When no read is issued, ram_raddr holds its last value and the pipeline valid bit is 0.
- Write/read collisions on the RAM are outside this block. Data follows RAM mode semantics.

## Timing
- Reset values: cmd_ready=0 during reset and 1 in the first cycle after. out_valid=0, out_last=0, busy=0, ram_raddr=0, state IDLE, buffer and pipeline empty.
- Command accepted at edge E:
  - First read address is driven in cycle E+1.
  - First word is visible on out_valid in cycle E+2+RD_LATENCY: 4 cycles for RD_LATENCY=2, 3 for RD_LATENCY=1.
- Throughput: with out_ready held high, one word per cycle sustained with no bubbles. An N-word burst ends its last word N−1 cycles after the first.
- Backpressure: while out_ready=0, issue stops once inflight+buf_count = OUT_DEPTH. It resumes the cycle after a pop.
- busy drops, and cmd_ready rises, in the cycle after the last-word pop. Minimum gap between bursts is 1 cycle.
- Reset mid-burst flushes the pipeline and buffer and returns to IDLE. No out_valid appears after reset is asserted, even for words still in the RAM pipeline.
- cmd_valid while busy is held off, not dropped. cmd_addr and cmd_len are sampled only at accept.

## Test plan
- Basic read: RAM[i]=i+0x100, cmd addr=2 len=4, out_ready=1 → out_data 0x102, 0x103, 0x104, 0x105 in consecutive cycles starting E+4; out_last on 0x105 only; busy low afterward.
- Wrap: cmd addr=14 len=4 → ram_raddr sequence 14, 15, 0, 1; data 0x10E, 0x10F, 0x100, 0x101.
- Backpressure: len=16, out_ready random 50% → exactly 16 words in address order 0..15, no duplicates or gaps. Buffer never exceeds OUT_DEPTH.
- Zero length and back-to-back:
  - cmd len=0 → no out_valid, cmd_ready stays 1.
  - Second command presented while busy → cmd_ready=0 until one cycle after the first burst's last pop, then accepted.
- Reset mid-burst: len=8, assert reset after 3 words popped → out_valid=0 from the next cycle and stays 0. A new cmd addr=5 len=1 after reset returns only 0x105 with out_last=1.
- RD_LATENCY=1 configuration: the basic read scenario repeated → first word at E+3, same data and ordering.

Source files
------------

// File: rtl/fim_gram_sdp_reader_if.sv
// Command and output stream bundle for fim_gram_sdp_reader.
//   cmd_*  : burst command (valid/ready, start address, word count)
//   out_*  : returned read data stream (valid/ready, data, last marker)
// master = burst requester / data consumer, slave = the reader.
interface fim_gram_sdp_reader_if #(
  parameter int BUS_SIZE_ADDR = 4,
  parameter int BUS_SIZE_DATA = 32,
  parameter int LEN_WIDTH     = BUS_SIZE_ADDR + 1
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [BUS_SIZE_ADDR-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]     cmd_len;
  logic                     out_valid;
  logic                     out_ready;
  logic [BUS_SIZE_DATA-1:0] out_data;
  logic                     out_last;

  modport master (
    output cmd_valid, cmd_addr, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fim_gram_sdp_reader.sv
// Read-side burst controller for the simple dual-port RAM.
// Accepts (addr, len) bursts, drives the registered RAM read address, tracks
// words in flight through the RAM read latency and returns them on a
// valid/ready stream with a last-word marker. A small output FIFO plus a
// credit check on issue absorbs downstream backpressure.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   bus         : slave side of command + output stream bundle
//   ram_raddr   : registered RAM read address
//   ram_dout    : RAM read data, RD_LATENCY cycles after the address
//   busy        : high from command accept until the final word is consumed
module fim_gram_sdp_reader #(
  parameter int BUS_SIZE_ADDR = 4,
  parameter int BUS_SIZE_DATA = 32,
  parameter int RD_LATENCY    = 2,
  parameter int LEN_WIDTH     = BUS_SIZE_ADDR + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  fim_gram_sdp_reader_if.slave     bus,
  output logic [BUS_SIZE_ADDR-1:0] ram_raddr,
  input  logic [BUS_SIZE_DATA-1:0] ram_dout,
  output logic                     busy
);
  localparam int OUT_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W     = $clog2(OUT_DEPTH);
  localparam int CNT_W     = $clog2(OUT_DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state;
  logic [BUS_SIZE_ADDR-1:0] addr_q;
  logic [LEN_WIDTH-1:0]     rem_q;

  // Bit k = word whose address was driven k cycles ago; the top bit lines up
  // with its data on ram_dout.
  logic [RD_LATENCY:0]      vld_p;
  logic [RD_LATENCY:0]      last_p;

  logic [BUS_SIZE_DATA-1:0] buf_data [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]     buf_last;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         buf_count;
  logic [CNT_W-1:0]         inflight;

  logic                     accept, pop, buf_wr, buf_full, credit_ok, issue;
  logic [BUS_SIZE_ADDR-1:0] issue_addr;
  logic [LEN_WIDTH-1:0]     issue_rem;
  logic                     issue_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int k = 0; k <= RD_LATENCY; k++) inflight = inflight + CNT_W'(vld_p[k]);
  end

  assign bus.cmd_ready = (state == IDLE) & ~reset;
  assign bus.out_valid = (buf_count != '0) & ~reset;
  assign bus.out_data  = buf_data[rd_ptr];
  assign bus.out_last  = buf_last[rd_ptr] & bus.out_valid;
  assign busy          = (state != IDLE);

  assign accept   = bus.cmd_valid & bus.cmd_ready;
  assign pop      = bus.out_valid & bus.out_ready;
  assign buf_wr   = vld_p[RD_LATENCY];
  assign buf_full = (buf_count == CNT_W'(OUT_DEPTH));

  // Every word in the pipeline already owns a buffer slot; a pop this cycle
  // frees one, so the issue can reuse it without a bubble.
  assign credit_ok = (inflight + buf_count) < (CNT_W'(OUT_DEPTH) + CNT_W'(pop));

  // The first read of a burst is issued on the accept edge itself so the
  // address is on the RAM in the very next cycle.
  assign issue = (state == IDLE)  ? (accept && bus.cmd_len != '0)
               : (state == ISSUE) ? (rem_q != '0 && credit_ok)
               : 1'b0;
  assign issue_addr = (state == IDLE) ? bus.cmd_addr : addr_q;
  assign issue_rem  = (state == IDLE) ? bus.cmd_len  : rem_q;
  assign issue_last = (issue_rem == LEN_WIDTH'(1));

  // ---- issue stage: address register, burst counters, FSM ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      ram_raddr <= '0;
      vld_p     <= '0;
    end else begin
      vld_p <= {vld_p[RD_LATENCY-1:0], issue};
      if (issue) begin
        ram_raddr <= issue_addr;
        addr_q    <= issue_addr + BUS_SIZE_ADDR'(1);
        rem_q     <= issue_rem - LEN_WIDTH'(1);
      end
      case (state)
        IDLE:    if (issue) state <= issue_last ? DRAIN : ISSUE;
        ISSUE:   if (issue && issue_last) state <= DRAIN;
        DRAIN:   if (pop && bus.out_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    last_p <= {last_p[RD_LATENCY-1:0], issue_last};
  end

  // ---- RAM return stage: capture into the output FIFO ----
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (buf_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      buf_count <= buf_count + CNT_W'(buf_wr) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (buf_wr) begin
      buf_data[wr_ptr] <= ram_dout;
      buf_last[wr_ptr] <= last_p[RD_LATENCY];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(buf_wr && buf_full));
endmodule
